// File: rtl/mips_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package mips_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        CALC,
        FIX
    } state_e;

    // Two's-complement magnitude when neg is set, pass-through otherwise.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// Decode-side bundle for the multiply/divide sequencer and HI/LO readout.
interface hilo_muldiv_ctrl_if;
    import mips_pkg::*;

    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic            flush;
    logic            mf_req;
    logic            busy;
    logic            done;
    logic            stall;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val, flush, mf_req,
        input  busy, done, stall, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, flush, mf_req,
        output busy, done, stall, hi, lo
    );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring shift-subtract divide.
module muldiv_step
    import mips_pkg::*;
(
    input  logic            is_div,
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] low,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] acc_next,
    output logic [XLEN-1:0] low_next,
    output logic            qbit
);
    logic [XLEN-1:0] addend;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;

    // Multiply consumes low[0] (LSB first); divide shifts in low's MSB.
    always_comb begin
        addend  = low[0] ? operand : '0;
        sum     = {1'b0, acc} + {1'b0, addend};
        shifted = {acc, low[XLEN-1]};
        qbit    = is_div && (shifted >= {1'b0, operand});
        // Only used when qbit is set, so the true difference fits XLEN bits.
        diff    = shifted[XLEN-1:0] - operand;
        if (is_div) begin
            acc_next = qbit ? diff : shifted[XLEN-1:0];
        end else begin
            acc_next = sum[XLEN:1];
        end
        low_next = {sum[0], low[XLEN-1:1]};
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer and owner of the architectural HI/LO registers.
module hilo_muldiv_ctrl #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ITER = 32
) (
    input  logic               clk,
    input  logic               rst,
    hilo_muldiv_ctrl_if.slave  bus
);
    import mips_pkg::*;

    localparam int unsigned CNT_W = $clog2(ITER);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
    logic [XLEN-1:0]   opnd_q, opnd_d, acc_q, acc_d, low_q, low_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic              res_neg_q, res_neg_d, rem_neg_q, rem_neg_d;
    logic              div_zero_q, div_zero_d, done_q, done_d;
    logic [XLEN-1:0]   step_acc, step_low;
    logic              step_qbit;
    logic              is_div, is_signed;
    logic [2*XLEN-1:0] prod;

    assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
    assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);

    muldiv_step u_step (
        .is_div   (is_div),
        .acc      (acc_q),
        .low      (low_q),
        .operand  (opnd_q),
        .acc_next (step_acc),
        .low_next (step_low),
        .qbit     (step_qbit)
    );

    // Next-state and datapath update; flush overrides everything outside IDLE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        low_d      = low_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        res_neg_d  = res_neg_q;
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;
        done_d     = 1'b0;
        prod       = {acc_q, low_q};

        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            state_d = PREP;
                            op_d    = bus.op;
                            a_d     = bus.rs_val;
                            b_d     = bus.rt_val;
                        end
                        OP_MTHI: hi_d = bus.rs_val;
                        OP_MTLO: lo_d = bus.rs_val;
                        default: ;
                    endcase
                end
            end
            PREP: begin
                // Divide: low holds the dividend, operand the divisor.
                // Multiply: low holds the multiplier, operand the multiplicand.
                opnd_d     = is_div ? mag(b_q, is_signed && b_q[XLEN-1])
                                    : mag(a_q, is_signed && a_q[XLEN-1]);
                low_d      = is_div ? mag(a_q, is_signed && a_q[XLEN-1])
                                    : mag(b_q, is_signed && b_q[XLEN-1]);
                acc_d      = '0;
                cnt_d      = '0;
                res_neg_d  = is_signed && (a_q[XLEN-1] ^ b_q[XLEN-1]);
                rem_neg_d  = is_signed && a_q[XLEN-1];
                div_zero_d = is_div && (b_q == '0);
                state_d    = CALC;
            end
            CALC: begin
                acc_d = step_acc;
                low_d = is_div ? {low_q[XLEN-2:0], step_qbit} : step_low;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (is_div) begin
                    if (div_zero_q) begin
                        lo_d = '1;
                        hi_d = a_q;
                    end else begin
                        lo_d = res_neg_q ? -low_q : low_q;
                        hi_d = rem_neg_q ? -acc_q : acc_q;
                    end
                end else begin
                    if (res_neg_q) begin
                        prod = -prod;
                    end
                    hi_d = prod[2*XLEN-1:XLEN];
                    lo_d = prod[XLEN-1:0];
                end
            end
        endcase

        if (bus.flush && (state_q != IDLE)) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, sign flags and architectural HI/LO.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            op_q       <= OP_NOP;
            a_q        <= '0;
            b_q        <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            low_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            res_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            low_q      <= low_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            res_neg_q  <= res_neg_d;
            rem_neg_q  <= rem_neg_d;
            div_zero_q <= div_zero_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = done_q;
    assign bus.stall = bus.mf_req && (state_q != IDLE);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
- Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU, plus owner of the architectural HI/LO registers.
- Sits beside the single-cycle ALU. Decode issues one operation with rs/rt values; the block iterates 32 shift-add/shift-subtract steps, then commits HI/LO.
- The ALU's MFHI/MFLO paths read the hi/lo outputs. The block raises stall for any MFHI/MFLO issued while an operation is in flight.

Parameters:
- XLEN, 32, operand/HI/LO width
- ITER, 32, iteration count (must equal XLEN)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  issue op this cycle (ignored unless idle)
- op  in  3  operation code (package enum)
- rs_val  in  32  dividend / multiplicand / MTHI-MTLO source
- rt_val  in  32  divisor / multiplier
- flush  in  1  abort in-flight operation
- mf_req  in  1  decode holds an MFHI/MFLO this cycle
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse: new HI/LO visible
- stall  out  1  mf_req & busy, combinational
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; hi=0, lo=0, busy=0, done=0; internal accumulators cleared. Reset mid-operation discards it and clears hi/lo.
- States: IDLE -> PREP (1 cycle) -> CALC (ITER cycles) -> FIX (1 cycle) -> IDLE.
- Accepted MULT/MULTU/DIV/DIVU: start sampled high in cycle 0 while IDLE.
  - busy=1 in cycles 1..34: PREP cycle 1, CALC cycles 2..33, FIX cycle 34.
  - hi/lo registered at the end of cycle 34.
  - Cycle 35: done=1, busy=0, state IDLE, new values on hi/lo.
  - A start in cycle 35 is accepted.
- MTHI/MTLO: accepted only in IDLE. Writes rs_val to hi/lo at that edge, visible next cycle. No busy, no done.
- start while busy: ignored, no error. Decode is responsible for stalling.
- op = NOP or undefined with start: no effect.
- PREP latches operands.
  - Signed ops: magnitudes |rs|, |rt|; record result sign (rs^rt) and remainder sign (sign of rs).
- CALC, multiply: 64-bit product via shift-add, one multiplier bit per cycle, LSB first.
- CALC, divide: restoring shift-subtract, one quotient bit per cycle, MSB first. 33-bit partial remainder.
- FIX:
  - Negate product if the product sign is set.
  - Divide: lo=quotient, negated if the quotient sign is set; hi=remainder, negated if rs was negative.
  - MULT/MULTU: {hi,lo} = 64-bit product.
- Divide by zero (DIV or DIVU, rt_val=0): still takes the full 34 cycles. Commits lo=32'hFFFFFFFF, hi=rs_val. Sign fix is skipped.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (natural wrap of magnitude arithmetic, no trap).
- flush:
  - In PREP/CALC/FIX: state->IDLE next cycle, hi/lo unchanged, no done.
  - Same cycle as start: flush wins, op not accepted.
  - flush and rst together: rst wins.
- done is never asserted in the same cycle as busy.
- stall mirrors busy whenever mf_req=1. hi/lo are never exposed mid-computation: outputs change only at the FIX commit or on MTHI/MTLO.

Decomposition:
- Shared package mips_pkg holds:
  - op enum: OP_NOP=0, OP_MULT=1, OP_MULTU=2, OP_DIV=3, OP_DIVU=4, OP_MTHI=5, OP_MTLO=6.
  - State enum: IDLE, PREP, CALC, FIX.
  - XLEN constant.
- One natural sub-module: muldiv_step. Pure combinational single iteration: given acc/partial remainder, operand and mode, returns next acc and quotient bit. Instantiated once in the FSM datapath.
- Iteration counter, sign flags and HI/LO registers stay in the top.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> done in cycle 35; hi=0xFFFFFFFE, lo=0x00000001; busy high exactly cycles 1..34.
- MULT rs=0xFFFFFFFF(-1) rt=0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFFB. DIV rs=0xFFFFFFF9(-7) rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=100 rt=0 -> after 34 busy cycles: lo=0xFFFFFFFF, hi=0x00000064. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Back-to-back and stall:
  - MTHI 0x1234 then MTLO 0x5678 in consecutive cycles -> hi=0x1234, lo=0x5678, no busy.
  - Then DIVU 10/3, with mf_req held through cycles 1..34 -> stall=1 on exactly those cycles; cycle 35: lo=3, hi=1.
- Flush and reset mid-op:
  - hi=0xAA, lo=0xBB preset; DIVU started; flush in cycle 10 -> busy=0 from cycle 11, hi=0xAA, lo=0xBB, no done.
  - Repeat with rst in cycle 10 -> hi=lo=0, IDLE.
- start held high during busy with different op -> ignored; only first op's result committed; a start in cycle 35 is accepted.
